// File: rtl/fifo2axi_unpack_if.sv
// AXI4-Stream bundle for the output side of fifo2axi_unpack.
// The master drives beats; the slave returns m_tready.
interface fifo2axi_unpack_if #(
   parameter int unsigned TDATA_WIDTH = 32,
   parameter int unsigned TUSER_WIDTH = 16
);
   logic [8*TDATA_WIDTH-1:0] m_tdata;
   logic [TDATA_WIDTH-1:0]   m_tstrb;
   logic [8*TUSER_WIDTH-1:0] m_tuser;
   logic                     m_tlast;
   logic                     m_tvalid;
   logic                     m_tready;

   modport master (
      output m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid,
      input  m_tready
   );

   modport slave (
      input  m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid,
      output m_tready
   );
endinterface

// File: rtl/fifo2axi_unpack.sv
// Rebuilds 256-bit AXI4-Stream packets from 202-bit cropped FWFT words, with phase checking.
// Define FIFO2AXI_STATS_EN to add pkt_cnt, beat_cnt and drop_cnt outputs.
module fifo2axi_unpack #(
   parameter int unsigned TDATA_WIDTH        = 32,
   parameter int unsigned TUSER_WIDTH        = 16,
   parameter int unsigned CROPPED_DATA_WIDTH = 24
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [8*CROPPED_DATA_WIDTH+9:0] din,
   input  logic                            din_valid,
   output logic                            din_rd,
   fifo2axi_unpack_if.master               m_axis,
   output logic                            err_seq
`ifdef FIFO2AXI_STATS_EN
   ,
   output logic [31:0]                     pkt_cnt,
   output logic [31:0]                     beat_cnt,
   output logic [31:0]                     drop_cnt
`endif
);

   localparam int unsigned DW = 8 * TDATA_WIDTH;
   localparam int unsigned UW = 8 * TUSER_WIDTH;
   localparam int unsigned PW = 8 * CROPPED_DATA_WIDTH;

   // P1..P4 are encoded as the phase they expect.
   localparam logic [2:0] HDR    = 3'd0;
   localparam logic [2:0] P1     = 3'd1;
   localparam logic [2:0] P2     = 3'd2;
   localparam logic [2:0] P3     = 3'd3;
   localparam logic [2:0] P4     = 3'd4;
   localparam logic [2:0] FLUSH  = 3'd5;
   localparam logic [2:0] RESYNC = 3'd6;

   logic [PW-1:0] payload;
   logic [4:0]    n;
   logic [2:0]    phase;
   logic          last, vmark;

   assign payload = din[PW+9:10];
   assign n       = din[9:5];
   assign phase   = din[4:2];
   assign last    = din[1];
   assign vmark   = din[0];

   logic [2:0]             state_q, state_d;
   logic [PW-1:0]          acc_q, acc_d;
   logic [UW-1:0]          hdr_user_q, hdr_user_d;
   logic                   first_q, first_d;
   logic [4:0]             flush_n_q, flush_n_d;
   logic                   err_q, err_d;
   logic [DW-1:0]          tdata_q, tdata_d;
   logic [TDATA_WIDTH-1:0] tstrb_q, tstrb_d;
   logic [UW-1:0]          tuser_q, tuser_d;
   logic                   tlast_q, tlast_d;
   logic                   tvalid_q, tvalid_d;

   logic                   out_free, pop, emit, bad, b_last;
   logic [DW-1:0]          b_data;
   logic [TDATA_WIDTH-1:0] b_strb;

   function automatic logic [TDATA_WIDTH-1:0] strb_of(input logic [4:0] cnt);
      logic [TDATA_WIDTH-1:0] s;
      for (int i = 0; i < int'(TDATA_WIDTH); i++) s[i] = (cnt == 5'd0) || (i < int'(cnt));
      return s;
   endfunction

   function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d,
                                                 input logic [TDATA_WIDTH-1:0] s);
      logic [DW-1:0] r;
      for (int i = 0; i < int'(TDATA_WIDTH); i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
      return r;
   endfunction

   assign out_free = !tvalid_q || m_axis.m_tready;
   assign pop      = !reset && din_valid && (state_q != FLUSH) && out_free;
   assign din_rd   = pop;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      hdr_user_d = hdr_user_q;
      first_d    = first_q;
      flush_n_d  = flush_n_q;
      err_d      = err_q;
      tdata_d    = tdata_q;
      tstrb_d    = tstrb_q;
      tuser_d    = tuser_q;
      tlast_d    = tlast_q;
      tvalid_d   = tvalid_q;
      emit       = 1'b0;
      bad        = 1'b0;
      b_data     = '0;
      b_strb     = '1;
      b_last     = 1'b0;

      if (state_q == FLUSH) begin
         if (out_free) begin
            emit    = 1'b1;
            b_data  = {{(DW-PW){1'b0}}, acc_q};
            b_strb  = strb_of(flush_n_q);
            b_last  = 1'b1;
            state_d = HDR;
         end
      end else if (pop) begin
         if (!vmark) begin
            bad = 1'b1;
         end else if (phase == 3'd0) begin
            // A header outside HDR/RESYNC breaks the current packet but is kept.
            if (state_q != HDR && state_q != RESYNC) err_d = 1'b1;
            hdr_user_d = payload[UW-1:0];
            first_d    = 1'b1;
            state_d    = P1;
         end else if (state_q != RESYNC) begin
            if (phase != state_q) begin
               bad = 1'b1;
            end else begin
               case (state_q)
                  P1: begin
                     b_data = {{(DW-PW){1'b0}}, payload};
                     if (!last) begin
                        acc_d   = payload;
                        state_d = P2;
                     end else if (n >= 5'd1 && n <= 5'd24) begin
                        emit = 1'b1; b_strb = strb_of(n); b_last = 1'b1; state_d = HDR;
                     end else bad = 1'b1;
                  end
                  P2: begin
                     b_data = {payload[63:0], acc_q};
                     if (!last || (n >= 5'd1 && n <= 5'd16)) begin
                        emit         = 1'b1;
                        acc_d[127:0] = payload[191:64];
                        flush_n_d    = n;
                        state_d      = last ? FLUSH : P3;
                     end else if (n == 5'd0 || n >= 5'd25) begin
                        emit = 1'b1; b_strb = strb_of(n); b_last = 1'b1; state_d = HDR;
                     end else bad = 1'b1;
                  end
                  P3: begin
                     b_data = {payload[127:0], acc_q[127:0]};
                     if (!last || (n >= 5'd1 && n <= 5'd8)) begin
                        emit        = 1'b1;
                        acc_d[63:0] = payload[191:128];
                        flush_n_d   = n;
                        state_d     = last ? FLUSH : P4;
                     end else if (n == 5'd0 || n >= 5'd17) begin
                        emit = 1'b1; b_strb = strb_of(n); b_last = 1'b1; state_d = HDR;
                     end else bad = 1'b1;
                  end
                  P4: begin
                     b_data = {payload, acc_q[63:0]};
                     if (!last) begin
                        emit = 1'b1; state_d = P1;
                     end else if (n == 5'd0 || n >= 5'd9) begin
                        emit = 1'b1; b_strb = strb_of(n); b_last = 1'b1; state_d = HDR;
                     end else bad = 1'b1;
                  end
                  default: bad = 1'b1;
               endcase
            end
         end
      end

      if (bad) begin
         err_d   = 1'b1;
         state_d = RESYNC;
      end

      if (emit) begin
         tvalid_d = 1'b1;
         tdata_d  = mask_bytes(b_data, b_strb);
         tstrb_d  = b_strb;
         tlast_d  = b_last;
         tuser_d  = first_q ? hdr_user_q : '0;
         first_d  = 1'b0;
      end else if (out_free) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HDR;
         acc_q      <= '0;
         hdr_user_q <= '0;
         first_q    <= 1'b0;
         flush_n_q  <= '0;
         err_q      <= 1'b0;
         tdata_q    <= '0;
         tstrb_q    <= '0;
         tuser_q    <= '0;
         tlast_q    <= 1'b0;
         tvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         hdr_user_q <= hdr_user_d;
         first_q    <= first_d;
         flush_n_q  <= flush_n_d;
         err_q      <= err_d;
         tdata_q    <= tdata_d;
         tstrb_q    <= tstrb_d;
         tuser_q    <= tuser_d;
         tlast_q    <= tlast_d;
         tvalid_q   <= tvalid_d;
      end
   end

   assign m_axis.m_tdata  = tdata_q;
   assign m_axis.m_tstrb  = tstrb_q;
   assign m_axis.m_tuser  = tuser_q;
   assign m_axis.m_tlast  = tlast_q;
   assign m_axis.m_tvalid = tvalid_q;
   assign err_seq         = err_q;

`ifdef FIFO2AXI_STATS_EN
   logic [31:0] pkt_cnt_q, beat_cnt_q, drop_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_q  <= '0;
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (tvalid_q && m_axis.m_tready) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (tlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (pop && state_q == RESYNC && !(vmark && phase == 3'd0)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
         end
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign beat_cnt = beat_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo2axi_unpack.sv
// Self-checking bench for fifo2axi_unpack: packets are modelled as byte streams and the
// expected beats are 32-byte slices of each stream.
module tb_fifo2axi_unpack;
   localparam int W = 202;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  strb;
      logic [127:0] user;
      logic         last;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  din;
   logic          din_valid;
   logic          din_rd;
   logic          err_seq;
`ifdef FIFO2AXI_STATS_EN
   logic [31:0]   pkt_cnt, beat_cnt, drop_cnt;
`endif

   fifo2axi_unpack_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(16)) axis ();

   fifo2axi_unpack #(.TDATA_WIDTH(32), .TUSER_WIDTH(16), .CROPPED_DATA_WIDTH(24)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_rd    (din_rd),
      .m_axis    (axis),
      .err_seq   (err_seq)
`ifdef FIFO2AXI_STATS_EN
      ,
      .pkt_cnt   (pkt_cnt),
      .beat_cnt  (beat_cnt),
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [W-1:0] wq[$];
   beat_t        expq[$];
   beat_t        rxq[$];
   int           checks = 0;
   int           fails  = 0;
   int           npops  = 0;
   int           valid_mode = 1;
   int           ready_mode = 1;
   logic [W-1:0] last_pop;
   logic         popped;
   logic         hold_chk = 1'b0;
   logic [$bits(beat_t):0] prev_out;
   int unsigned  exp_beats = 0, exp_pkts = 0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [191:0] rnd192();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [W-1:0] mk(input logic [191:0] p, input logic [4:0] n,
                                       input logic [2:0] ph, input logic lst);
      return {p, n, ph, lst, 1'b1};
   endfunction

   function automatic beat_t cur_beat();
      beat_t b;
      b.data = axis.m_tdata;
      b.strb = axis.m_tstrb;
      b.user = axis.m_tuser;
      b.last = axis.m_tlast;
      return b;
   endfunction

   // One clock: check hold-under-stall, drive inputs, sample handshakes just before the edge.
   task automatic step();
      @(negedge clk);
      if (hold_chk) check("axi hold", 512'({axis.m_tvalid, cur_beat()}), 512'(prev_out));
      din_valid = (wq.size() != 0) &&
                  (valid_mode == 1 || (valid_mode == 2 && $urandom_range(0, 3) != 0));
      din = (wq.size() != 0) ? wq[0] : '0;
      axis.m_tready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 2) != 0);
      #1;
      check("din_rd without din_valid", 512'(din_rd && !din_valid), 512'(0));
      popped = 1'b0;
      if (din_rd && din_valid && wq.size() != 0) begin
         last_pop = wq.pop_front();
         popped   = 1'b1;
         npops++;
      end
      if (axis.m_tvalid && axis.m_tready) rxq.push_back(cur_beat());
      hold_chk = axis.m_tvalid && !axis.m_tready;
      prev_out = {axis.m_tvalid, cur_beat()};
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         reset = 1'b1;
         din_valid = 1'b1;
         din = mk(rnd192(), 5'd0, 3'd0, 1'b0);
         axis.m_tready = 1'b0;
         #1;
         check("din_rd in reset", 512'(din_rd), 512'(0));
      end
      check("reset outputs", 512'({axis.m_tvalid, axis.m_tlast, axis.m_tdata, axis.m_tstrb,
                                   axis.m_tuser, err_seq}), 512'(0));
`ifdef FIFO2AXI_STATS_EN
      check("reset counters", 512'({pkt_cnt, beat_cnt, drop_cnt}), 512'(0));
`endif
      reset = 1'b0;
      din_valid = 1'b0;
      hold_chk = 1'b0;
      wq.delete();
      exp_beats = 0;
      exp_pkts = 0;
   endtask

   // Reference: header + 24-byte words cycling phases 1..4; beats are 32-byte slices.
   task automatic add_packet(input int len, input logic [127:0] tu, input int keep_w,
                             input int keep_b);
      logic [7:0]   b[$];
      logic [W-1:0] words[$];
      beat_t        beats[$];
      logic [191:0] p;
      beat_t        bt;
      int           nw, nb;
      for (int i = 0; i < len; i++) b.push_back(8'($urandom()));
      p = rnd192();
      p[127:0] = tu;
      words.push_back(mk(p, 5'd0, 3'd0, 1'b0));
      nw = (len + 23) / 24;
      for (int j = 0; j < nw; j++) begin
         p = '0;
         for (int k = 0; k < 24; k++) if (24*j + k < len) p[8*k +: 8] = b[24*j + k];
         words.push_back(mk(p, (j == nw-1) ? 5'(len % 32) : 5'd0, 3'(j % 4 + 1), j == nw-1));
      end
      nb = (len + 31) / 32;
      for (int j = 0; j < nb; j++) begin
         bt = '0;
         for (int k = 0; k < 32; k++) begin
            if (32*j + k < len) begin
               bt.data[8*k +: 8] = b[32*j + k];
               bt.strb[k] = 1'b1;
            end
         end
         bt.user = (j == 0) ? tu : 128'h0;
         bt.last = (j == nb-1);
         beats.push_back(bt);
      end
      for (int j = 0; j < words.size(); j++) if (keep_w < 0 || j < keep_w) wq.push_back(words[j]);
      for (int j = 0; j < beats.size(); j++) begin
         if (keep_b < 0 || j < keep_b) begin
            expq.push_back(beats[j]);
            exp_beats++;
         end
      end
      if (keep_b < 0) exp_pkts++;
   endtask

   task automatic drain(input string tag, input int budget);
      int c = 0;
      while ((wq.size() != 0 || rxq.size() < expq.size()) && c < budget) begin
         step();
         c++;
      end
      repeat (4) step();
      check({tag, " beat count"}, 512'(rxq.size()), 512'(expq.size()));
      for (int i = 0; i < expq.size(); i++)
         if (i < rxq.size()) check($sformatf("%s beat%0d", tag, i), 512'(rxq[i]), 512'(expq[i]));
      rxq.delete();
      expq.delete();
   endtask

   initial begin
      int c;
      int p0;
      reset = 1'b1;
      din = '0;
      din_valid = 1'b0;
      axis.m_tready = 1'b0;
      do_reset();

      // 64 bytes: ph0, ph1, ph2, ph3 last n=0
      add_packet(64, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978, -1, -1);
      drain("pkt64", 200);
      check("pkt64 err_seq", 512'(err_seq), 512'(0));

      // 40 bytes ends ph2 n=8: FLUSH cycle must not pop even with a word waiting
      add_packet(40, 128'hfeed_0040, -1, -1);
      add_packet(32, 128'hfeed_0032, -1, -1);
      c = 0;
      do begin
         step();
         c++;
      end while (!(popped && last_pop[1] && last_pop[4:2] == 3'd2) && c < 100);
      step();
      check("flush din_rd", 512'({din_valid, din_rd}), 512'(2'b10));
      drain("pkt40", 300);

      add_packet(20, 128'hfeed_0020, -1, -1);
      drain("pkt20", 200);

      // Backpressure: stall with a beat pending for 5 cycles
      ready_mode = 0;
      add_packet(96, 128'hbead_0096, -1, -1);
      c = 0;
      while (!axis.m_tvalid && c < 50) begin
         step();
         c++;
      end
      p0 = npops;
      repeat (5) step();
      check("stall pops", 512'(npops), 512'(p0));
      check("stall tvalid", 512'(axis.m_tvalid), 512'(1));
      ready_mode = 2;
      valid_mode = 2;
      drain("backpressure", 500);
      ready_mode = 1;
      valid_mode = 1;

      // Phase error: ph1 then ph3; three non-header words dropped; then a good packet
      wq.push_back(mk(rnd192(), 5'd0, 3'd0, 1'b0));
      wq.push_back(mk(rnd192(), 5'd0, 3'd1, 1'b0));
      wq.push_back(mk(rnd192(), 5'd0, 3'd3, 1'b0));
      wq.push_back(mk(rnd192(), 5'd0, 3'd1, 1'b0));
      wq.push_back(mk(rnd192(), 5'd5, 3'd2, 1'b1));
      wq.push_back(mk(rnd192(), 5'd0, 3'd4, 1'b0));
      add_packet(64, 128'hacce_5500, -1, -1);
      drain("resync", 300);
      check("err_seq sticky", 512'(err_seq), 512'(1));
`ifdef FIFO2AXI_STATS_EN
      check("drop_cnt", 512'(drop_cnt), 512'(3));
`endif

      // Reset after beat A of a 96-byte packet, then a fresh 32-byte packet
      add_packet(96, 128'hdead_0096, -1, 1);
      c = 0;
      while (rxq.size() < 1 && c < 100) begin
         step();
         c++;
      end
      do_reset();
      drain("pre-reset partial", 50);
      add_packet(32, 128'hc0de_0032, -1, -1);
      drain("pkt32 after reset", 200);

      // Header mid-packet: broken packet keeps its A beat, no tlast, new packet follows
      add_packet(96, 128'h0bad_0096, 3, 1);
      add_packet(50, 128'h600d_0050, -1, -1);
      drain("mid header", 300);
      check("mid header err_seq", 512'(err_seq), 512'(1));

      // Random lengths, gaps and backpressure
      valid_mode = 2;
      ready_mode = 2;
      for (int i = 0; i < 30; i++)
         add_packet($urandom_range(1, 200), {$urandom(), $urandom(), $urandom(), $urandom()},
                    -1, -1);
      drain("random", 20000);
`ifdef FIFO2AXI_STATS_EN
      check("pkt_cnt", 512'(pkt_cnt), 512'(exp_pkts));
      check("beat_cnt", 512'(beat_cnt), 512'(exp_beats));
      check("drop_cnt final", 512'(drop_cnt), 512'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end
endmodule
